// File: rtl/mem_dump_tx.sv
// mem_dump_tx: streams a window of 32-bit memory words as "%b\n" ASCII lines.
// Defining MEM_DUMP_CRLF_EN ends every line with CR LF instead of a bare LF.
module mem_dump_tx #(
  parameter int ADDR_W = 10
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_BITS  = 3'd3,
`ifdef MEM_DUMP_CRLF_EN
    S_CR    = 3'd4,
`endif
    S_LF    = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  function automatic logic [7:0] bit_char(input logic b);
    return b ? 8'h31 : 8'h30;
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic [31:0]       shreg_q, shreg_d;
  logic [4:0]        bitcnt_q, bitcnt_d;
  logic              xfer_s;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              tx_last_q, tx_last_d;

  assign xfer_s = tx_valid_q & tx_ready;

  // State register
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (word_count == CNT_ZERO) state_d = S_DONE;
          else                        state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_BITS;
      S_BITS: begin
        if (xfer_s && bitcnt_q == 5'd0) begin
`ifdef MEM_DUMP_CRLF_EN
          state_d = S_CR;
`else
          state_d = S_LF;
`endif
        end else begin
          state_d = S_BITS;
        end
      end
`ifdef MEM_DUMP_CRLF_EN
      S_CR: begin
        if (xfer_s) state_d = S_LF;
        else        state_d = S_CR;
      end
`endif
      S_LF: begin
        if (xfer_s) begin
          if (remain_q == CNT_ONE) state_d = S_DONE;
          else                     state_d = S_FETCH;
        end else begin
          state_d = S_LF;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: window capture, word load, bit shifting, address walk
  always_comb begin
    addr_d   = addr_q;
    remain_d = remain_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && word_count != CNT_ZERO) begin
          addr_d   = base_addr;
          remain_d = word_count;
        end else begin
          addr_d   = addr_q;
        end
      end
      S_LOAD: begin
        shreg_d  = mem_rdata;
        bitcnt_d = 5'd31;
      end
      S_BITS: begin
        if (xfer_s) begin
          shreg_d  = {shreg_q[30:0], 1'b0};
          bitcnt_d = bitcnt_q - 5'd1;
        end else begin
          shreg_d  = shreg_q;
        end
      end
      S_LF: begin
        // Address wraps naturally at 2^ADDR_W.
        if (xfer_s) begin
          addr_d   = addr_q + ADDR_ONE;
          remain_d = remain_q - CNT_ONE;
        end else begin
          addr_d   = addr_q;
        end
      end
      default: shreg_d = shreg_q;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      addr_q   <= {ADDR_W{1'b0}};
      remain_q <= CNT_ZERO;
      shreg_q  <= 32'h0000_0000;
      bitcnt_q <= 5'd0;
    end else begin
      addr_q   <= addr_d;
      remain_q <= remain_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  // Output decode from the upcoming state so every output leaves a flop
  always_comb begin
    busy_d     = 1'b0;
    done_d     = 1'b0;
    mem_rd_d   = 1'b0;
    mem_addr_d = addr_d;
    tx_valid_d = 1'b0;
    tx_data_d  = 8'h00;
    tx_last_d  = 1'b0;
    case (state_d)
      S_FETCH: begin
        busy_d   = 1'b1;
        mem_rd_d = 1'b1;
      end
      S_LOAD: busy_d = 1'b1;
      S_BITS: begin
        busy_d     = 1'b1;
        tx_valid_d = 1'b1;
        tx_data_d  = bit_char(shreg_d[31]);
      end
`ifdef MEM_DUMP_CRLF_EN
      S_CR: begin
        busy_d     = 1'b1;
        tx_valid_d = 1'b1;
        tx_data_d  = 8'h0D;
      end
`endif
      S_LF: begin
        busy_d     = 1'b1;
        tx_valid_d = 1'b1;
        tx_data_d  = 8'h0A;
        tx_last_d  = (remain_d == CNT_ONE);
      end
      S_DONE:  done_d = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

  // Output registers
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= {ADDR_W{1'b0}};
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_last_q  <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_last_q  <= tx_last_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign tx_last  = tx_last_q;

endmodule

// File: doc/mem_dump_tx.md
# mem_dump_tx

Memory dump transmitter for the mips32 bench and debug path. It reads a window of 32-bit words from a synchronous-read memory port. Each word is emitted as an ASCII byte stream, one line per word: 32 characters '0'/'1', MSB first, then newline. This is the same "%b\n" text format the program loader consumes, so a dumped region can be reloaded unchanged. The block sits beside the CPU memory and is typically started once the CPU reports HALTED.

## Interface
- ADDR_W, 10, memory word-address width (1024 words).
- clk1  in  1  single clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin dump; sampled only in IDLE, ignored while busy.
- base_addr  in  ADDR_W  first word address; captured on accepted start.
- word_count  in  ADDR_W+1  number of words, 0..2^ADDR_W; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  single-cycle completion pulse.
- mem_rd  out  1  read strobe; data is returned on mem_rdata the following cycle.
- mem_addr  out  ADDR_W  read address.
- mem_rdata  in  32  read data, valid the cycle after mem_rd.
- tx_data  out  8  output byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts byte.
- tx_last  out  1  high with the final newline byte of the final word.

## Operation
- States: IDLE, FETCH, LOAD, BITS, CR (only with CRLF_EN), LF, DONE.
- IDLE:
  - start=1 and word_count=0: go to DONE.
  - start=1 and word_count≠0: capture base_addr and word_count, go to FETCH.
- FETCH (1 cycle): mem_rd=1, mem_addr=current address; go to LOAD.
- LOAD (1 cycle): latch mem_rdata into a 32-bit shift register; bit index=31; go to BITS.
- BITS: tx_data = 0x31 if the current bit is 1, else 0x30.
  - On each transfer, shift; after bit 0 transfers, go to CR or LF.
- CR: tx_data=0x0D; go to LF on transfer.
- LF: tx_data=0x0A.
  - On transfer, increment the address modulo 2^ADDR_W and decrement the remaining count.
  - Remaining count reaches 0: go to DONE. Otherwise go to FETCH.
- DONE (1 cycle): done=1, busy=0; go to IDLE.
- Transfer occurs when tx_valid and tx_ready are both high. While tx_valid=1 and tx_ready=0, tx_data and tx_last are held stable. tx_valid does not drop without a transfer.
- tx_valid is high only in BITS, CR and LF.
- tx_last = LF state AND remaining count = 1.
- Address wrap: base 2^ADDR_W−1 followed by the next word reads address 0. No error is raised.
- A start during busy is dropped and has no side effect on the current dump.
- Reset mid-operation: on the edge with rst_n=0, the block goes to IDLE and all counters clear. The partially sent line is abandoned; no done pulse is generated.

## Timing
- Reset values: busy=0, done=0, mem_rd=0, mem_addr=0, tx_data=0, tx_valid=0, tx_last=0.
- Start accepted at edge E0:
  - FETCH occupies cycle 1 after E0.
  - LOAD occupies cycle 2.
  - First tx_valid is in cycle 3.
- With tx_ready held at 1:
  - 35 cycles per word (2 fetch + 33 bytes), 36 with CRLF_EN.
  - done is high in the cycle after the final LF transfer.
- word_count=0: done is high in cycle 1 after E0. No mem_rd and no tx_valid occur.
- mem_rd is never asserted outside FETCH. Exactly one read is issued per word.

## Configuration
- MEM_DUMP_CRLF_EN defined: each line ends with 0x0D,0x0A (34 bytes/word); CR state is present.
- Not defined: each line ends with 0x0A only (33 bytes/word); CR state is not compiled.
- tx_last always accompanies the final 0x0A in both builds.

## Test plan
- Single word, mem[0]=32'h8000_0001, base=0, count=1, tx_ready=1:
  - Bytes: 0x31, 30×0x30, 0x31, 0x0A.
  - tx_last only on 0x0A.
  - done one cycle later; total 36 cycles from start to done.
- Backpressure: count=4 with tx_ready pseudo-random (~50%):
  - Byte stream identical to the tx_ready=1 run.
  - tx_data/tx_last stable during every stall; exactly 4 mem_rd pulses.
- Zero count: start with word_count=0:
  - done in cycle 1 after start; busy never high; no mem_rd, no tx_valid.
- Wrap: ADDR_W=10, base=1023, count=2:
  - mem_addr sequence 1023 then 0; two lines output; tx_last on the second 0x0A only.
- Reset mid-stream: rst_n=0 for one cycle after the 10th byte of word 0:
  - Following cycle: tx_valid=0, busy=0, no done pulse.
  - A new start then produces a complete, correct dump.
- MEM_DUMP_CRLF_EN build, mem[0]=32'hFFFF_FFFF, count=1:
  - Bytes: 32×0x31, 0x0D, 0x0A; tx_last on 0x0A only.
